// File: rtl/div_result_bcd.sv
// div_result_bcd: converts a 4-bit quotient/remainder pair into two-digit BCD
// using a sequential double-dabble (four shift steps per channel) with a
// valid/ready handshake on both sides.
// Optional build macro: DIV_RESULT_BCD_SEG_EN adds registered active-low
// seven-segment encodings (bit order gfedcba) of the four digits.
module div_result_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] quotient,
  input  logic [3:0] remainder,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic [3:0] r_tens,
  output logic [3:0] r_ones,
`ifdef DIV_RESULT_BCD_SEG_EN
  output logic [6:0] seg_q_tens,
  output logic [6:0] seg_q_ones,
  output logic [6:0] seg_r_tens,
  output logic [6:0] seg_r_ones,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q;

  // Channel 0 carries the quotient, channel 1 the remainder.
  logic [1:0][3:0] bin_q;
  logic [1:0][7:0] acc_q;
  logic [1:0][3:0] bin_d;
  logic [1:0][7:0] acc_d;
  logic [1:0]      cnt_q;
  // Set once the step counter has wrapped 3->0, i.e. all four steps are done;
  // the following edge moves the accumulators into the digit registers.
  logic            wrap_q;

  // One double-dabble step per channel: correct the ones digit, then shift.
  // With a 4-bit source the tens digit never exceeds 1, so it needs no
  // correction of its own.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dabble
    logic [3:0]  ones_adj;
    logic [11:0] shifted;
    assign ones_adj   = (acc_q[gi][3:0] >= 4'd5) ? (acc_q[gi][3:0] + 4'd3)
                                                 : acc_q[gi][3:0];
    assign shifted    = {acc_q[gi][6:4], ones_adj, bin_q[gi], 1'b0};
    assign acc_d[gi]  = shifted[11:4];
    assign bin_d[gi]  = shifted[3:0];
  end

  // Handshake flags decoded straight from state.
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

`ifdef DIV_RESULT_BCD_SEG_EN
  // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = 7'h7F;
    endcase
    return pattern;
  endfunction
`endif

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      out_valid  <= 1'b0;
      q_tens     <= '0;
      q_ones     <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
`ifdef DIV_RESULT_BCD_SEG_EN
      seg_q_tens <= 7'h40;
      seg_q_ones <= 7'h40;
      seg_r_tens <= 7'h40;
      seg_r_ones <= 7'h40;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q   <= {remainder, quotient};
            acc_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (wrap_q) begin
            // Conversion complete: publish digits and wait for the consumer.
            q_tens     <= acc_q[0][7:4];
            q_ones     <= acc_q[0][3:0];
            r_tens     <= acc_q[1][7:4];
            r_ones     <= acc_q[1][3:0];
`ifdef DIV_RESULT_BCD_SEG_EN
            seg_q_tens <= seg7(acc_q[0][7:4]);
            seg_q_ones <= seg7(acc_q[0][3:0]);
            seg_r_tens <= seg7(acc_q[1][7:4]);
            seg_r_ones <= seg7(acc_q[1][3:0]);
`endif
            out_valid  <= 1'b1;
            wrap_q     <= 1'b0;
            state_q    <= HOLD;
          end else begin
            acc_q  <= acc_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_q + 2'd1;
            wrap_q <= (cnt_q == 2'd3);
          end
        end
        HOLD: begin
          // in_valid is ignored here; the next pair waits for IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Testbench for div_result_bcd: directed cases plus randomized pairs checked
// against a decimal-arithmetic reference (value / 10, value % 10).
module tb_div_result_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q_tens, q_ones, r_tens, r_ones;
  logic       busy;
`ifdef DIV_RESULT_BCD_SEG_EN
  logic [6:0] seg_q_tens, seg_q_ones, seg_r_tens, seg_r_ones;
`endif

  div_result_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_tens    (q_tens),
    .q_ones    (q_ones),
    .r_tens    (r_tens),
    .r_ones    (r_ones),
`ifdef DIV_RESULT_BCD_SEG_EN
    .seg_q_tens(seg_q_tens),
    .seg_q_ones(seg_q_ones),
    .seg_r_tens(seg_r_tens),
    .seg_r_ones(seg_r_ones),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  // Expected digits {q_tens, q_ones, r_tens, r_ones} of the last result.
  logic [15:0] exp_last = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion from plain decimal arithmetic.
  function automatic logic [15:0] ref_digits(input int q, input int r);
    logic [3:0] qt, qo, rt, ro;
    qt = 4'(q / 10);
    qo = 4'(q % 10);
    rt = 4'(r / 10);
    ro = 4'(r % 10);
    return {qt, qo, rt, ro};
  endfunction

  // Active-low gfedcba table for decimal digits.
  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (d < 10) ? t[d] : 7'h7F;
  endfunction

  task automatic check_digits(input string tag, input logic [15:0] e);
    check({tag, ".q_tens"}, q_tens, e[15:12]);
    check({tag, ".q_ones"}, q_ones, e[11:8]);
    check({tag, ".r_tens"}, r_tens, e[7:4]);
    check({tag, ".r_ones"}, r_ones, e[3:0]);
`ifdef DIV_RESULT_BCD_SEG_EN
    check({tag, ".seg_q_tens"}, seg_q_tens, ref_seg(e[15:12]));
    check({tag, ".seg_q_ones"}, seg_q_ones, ref_seg(e[11:8]));
    check({tag, ".seg_r_tens"}, seg_r_tens, ref_seg(e[7:4]));
    check({tag, ".seg_r_ones"}, seg_r_ones, ref_seg(e[3:0]));
`endif
  endtask

  // One full transaction from IDLE: accept, four SHIFT cycles, result at E+5,
  // 'hold' backpressure cycles with in_valid toggling, then the handshake.
  task automatic run_pair(input string tag, input int q, input int r, input int hold);
    logic [15:0] e;
    e = ref_digits(q, r);
    check({tag, ".pre_in_ready"}, in_ready, 1'b1);
    quotient  = 4'(q);
    remainder = 4'(r);
    in_valid  = 1'b1;
    @(posedge clk); #1;                      // accepting edge E
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      quotient  = 4'($urandom);
      remainder = 4'($urandom);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);              // must be ignored outside HOLD
      @(posedge clk); #1;
      check({tag, ".shift_valid"}, out_valid, 1'b0);
      check({tag, ".shift_busy"}, busy, 1'b1);
      check({tag, ".shift_in_ready"}, in_ready, 1'b0);
      check({tag, ".shift_digits"}, {q_tens, q_ones, r_tens, r_ones}, exp_last);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;                      // E+5
    check({tag, ".valid_at_E5"}, out_valid, 1'b1);
    check({tag, ".busy_hold"}, busy, 1'b1);
    check_digits(tag, e);
    exp_last = e;
    for (int h = 0; h < hold; h++) begin
      in_valid  = ~in_valid;
      quotient  = 4'($urandom);
      remainder = 4'($urandom);
      @(posedge clk); #1;
      check({tag, ".bp_valid"}, out_valid, 1'b1);
      check({tag, ".bp_in_ready"}, in_ready, 1'b0);
      check({tag, ".bp_busy"}, busy, 1'b1);
      check({tag, ".bp_digits"}, {q_tens, q_ones, r_tens, r_ones}, e);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;                        // must not be taken on the handshake edge
    @(posedge clk); #1;
    check({tag, ".hs_valid"}, out_valid, 1'b0);
    check({tag, ".hs_in_ready"}, in_ready, 1'b1);
    check({tag, ".hs_busy"}, busy, 1'b0);
    check({tag, ".hs_digits"}, {q_tens, q_ones, r_tens, r_ones}, e);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    $display("txn %s: q=%0d r=%0d hold=%0d -> %0d%0d %0d%0d", tag, q, r, hold,
             q_tens, q_ones, r_tens, r_ones);
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    quotient  = '0;
    remainder = '0;
    #1;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.busy", busy, 1'b0);
    check_digits("rst", 16'h0000);
    in_valid = 1'b1;                         // ignored while reset is held
    @(posedge clk); @(posedge clk); #1;
    check("rst_held.busy", busy, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.in_ready", in_ready, 1'b1);

    run_pair("extremes", 15, 0, 0);
    run_pair("mixed", 9, 12, 2);
    run_pair("backpressure", 5, 3, 10);
    run_pair("seg_case", 15, 9, 1);

    // Reset pulsed two edges into SHIFT aborts the conversion.
    quotient  = 4'd13;
    remainder = 4'd11;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.in_ready", in_ready, 1'b1);
    check("abort.busy", busy, 1'b0);
    check_digits("abort", 16'h0000);
    exp_last = '0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) cyc++;
    end
    check("abort.no_valid_after", cyc, 0);
    $display("txn abort: reset during SHIFT, spurious valids=%0d", cyc);

    // Back-to-back pairs with out_ready held high and in_valid held high.
    out_ready = 1'b1;
    quotient  = 4'd3;
    remainder = 4'd1;
    in_valid  = 1'b1;
    @(posedge clk); #1;                      // accept first pair
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b.lat1", cyc, 5);
    check_digits("b2b.r1", ref_digits(3, 1));
    quotient  = 4'd14;
    remainder = 4'd7;
    @(posedge clk); #1;
    check("b2b.gap_valid", out_valid, 1'b0);
    check("b2b.gap_in_ready", in_ready, 1'b1);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b.valid_spacing", cyc, 7);
    check_digits("b2b.r2", ref_digits(14, 7));
    exp_last = ref_digits(14, 7);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b.end_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
    $display("txn b2b: (3,1) then (14,7) -> %0d%0d %0d%0d", q_tens, q_ones, r_tens, r_ones);

    // Randomized pairs with random backpressure.
    for (int n = 0; n < 25; n++) begin
      run_pair("rand", int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: a quotient/remainder pair is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a pair this cycle.
REQ-005 SHALL have port quotient, input, 4 bits: unsigned divider quotient, 0..15.
REQ-006 SHALL have port remainder, input, 4 bits: unsigned divider remainder, 0..15.
REQ-007 SHALL have port out_valid, output, 1 bit: BCD result is held and valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-009 SHALL have ports q_tens, q_ones, r_tens, r_ones, outputs, 4 bits each: registered BCD digits.
REQ-010 SHALL have port busy, output, 1 bit: high in every state other than IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and HOLD.
REQ-012 SHALL drive in_ready high only in IDLE; it SHALL be decoded from state.
REQ-013 In IDLE, when in_valid is high, SHALL at the clock edge:
  - capture quotient and remainder into two 4-bit shift registers;
  - clear both 8-bit BCD accumulators;
  - clear the 2-bit step counter;
  - enter SHIFT.
REQ-014 SHALL perform one double-dabble step per channel on each SHIFT cycle: if accumulator ones >= 5, add 3, then shift {tens, ones, bin} left by one.
REQ-015 SHALL leave SHIFT after exactly 4 steps, when the counter has wrapped 3->0.
REQ-016 On leaving SHIFT, SHALL load q_tens/q_ones/r_tens/r_ones from the accumulators, set out_valid and enter HOLD.
REQ-017 SHALL assert out_valid exactly 5 clock edges after the accepting edge.
REQ-018 SHALL keep the tens digits at value 0 or 1; upper bits of the tens digits SHALL always be 0.
REQ-019 In HOLD, SHALL keep all digit outputs and out_valid stable while out_ready is low; in_valid SHALL be ignored.
REQ-020 In HOLD with out_ready high, SHALL clear out_valid and return to IDLE at that edge; the next pair SHALL NOT be accepted in that same cycle.
REQ-021 SHALL keep digit outputs at their last values outside HOLD; they SHALL change only on the SHIFT->HOLD transition.
REQ-022 SHALL ignore out_ready outside HOLD.

Reset
REQ-023 While rst is high, SHALL force:
  - state = IDLE;
  - out_valid = 0;
  - busy = 0;
  - all digits = 0;
  - shift registers, accumulators and counter = 0.
REQ-024 SHALL have in_ready = 1 during and after reset.
REQ-025 A reset asserted in SHIFT or HOLD SHALL abort the conversion; no out_valid SHALL be produced for the aborted pair.

Configuration
REQ-026 With macro DIV_RESULT_BCD_SEG_EN defined:
  - SHALL add outputs seg_q_tens, seg_q_ones, seg_r_tens and seg_r_ones, 7 bits each;
  - these SHALL be active-low, bit order gfedcba;
  - they SHALL be registered on the same edge as the digits;
  - encodings: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10;
  - all four SHALL reset to 0x40.
REQ-027 Without DIV_RESULT_BCD_SEG_EN, SHALL omit these ports and their logic entirely; all other behaviour SHALL be identical.

Verification
REQ-028 Extremes: quotient=15, remainder=0, accepted at edge E -> at E+5: out_valid=1, q_tens=1, q_ones=5, r_tens=0, r_ones=0.
REQ-029 Mixed values: quotient=9, remainder=12 -> q_tens=0, q_ones=9, r_tens=1, r_ones=2; busy=1 from E+1 until the handshake completes.
REQ-030 Backpressure: out_ready=0 for 10 cycles while in_valid toggles with new data -> digits and out_valid stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-031 Reset mid-conversion: rst pulsed at E+2 during SHIFT -> all outputs 0, in_ready=1, and no out_valid afterwards without a new accept.
REQ-032 Back-to-back: pairs (3,1) then (14,7) with out_ready tied high -> two results (0,3,0,1) and (1,4,0,7); second accept no earlier than the cycle after the first out_valid.
REQ-033 With DIV_RESULT_BCD_SEG_EN: quotient=15, remainder=9 -> seg_q_tens=0x79, seg_q_ones=0x12, seg_r_tens=0x40, seg_r_ones=0x10.
